store_queue: RTL and testbench
==============================

STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of store entries (power of two, at least 2).
REQ-002 SHALL have parameter TAG_W, default 5, ROB tag width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port alloc_valid  input  1  dispatch requests a store entry.
REQ-006 SHALL have port alloc_tag  input  TAG_W  ROB tag of the dispatched store.
REQ-007 SHALL have port alloc_sh  input  1  0 = sw, 1 = sh.
REQ-008 SHALL have port alloc_ready  output  1  entry available.
REQ-009 SHALL have port exec_valid  input  1  FU mem has resolved a store.
REQ-010 SHALL have port exec_tag  input  TAG_W  tag of the resolved store.
REQ-011 SHALL have port exec_addr  input  32  effective byte address.
REQ-012 SHALL have port exec_data  input  32  ps2 store data.
REQ-013 SHALL have port commit_valid  input  1  ROB retires a store.
REQ-014 SHALL have port commit_tag  input  TAG_W  tag of the retiring store.
REQ-015 SHALL have port flush  input  1  mispredict recovery.
REQ-016 SHALL have port load_addr  input  32  address of the load asking to issue.
REQ-017 SHALL have port load_block  output  1  load must not issue this cycle.
REQ-018 SHALL have ports store_wb (1), wb_addr (32), wb_data (32), wb_sh (1), wb_tag (TAG_W)  output  registered write to data memory.
REQ-019 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-020 SHALL hold a circular buffer with head/tail pointers; each entry holds valid, tag, sh, addr, data, ready, committed.
REQ-021 SHALL drive alloc_ready = (count != DEPTH), combinational from state at cycle start; no same-cycle bypass from drain.
REQ-022 SHALL, on alloc_valid && alloc_ready, write the tail entry (valid=1, ready=0, committed=0) and advance tail modulo DEPTH.
REQ-023 SHALL ignore alloc_valid when alloc_ready is 0; no error is flagged.
REQ-024 SHALL, on exec_valid, set addr, data and ready=1 in the valid entry whose tag equals exec_tag; with no match, no state changes.
REQ-025 SHALL, on commit_valid, set committed=1 in the valid entry whose tag equals commit_tag; with no match, the commit is ignored.
REQ-026 SHALL drain at most one entry per cycle: when the head entry is valid, ready and committed, the next edge sets store_wb=1, loads wb_* from that entry, clears the entry and advances head.
REQ-027 SHALL drive store_wb=0 in every cycle without a drain; wb_* hold their last values.
REQ-028 SHALL, on flush, clear every entry with committed=0 and set tail = head + (number of committed entries) modulo DEPTH; committed entries are contiguous from head.
REQ-029 SHALL give flush priority over alloc, exec and commit in the same cycle; a drain in the same cycle still occurs.
REQ-030 SHALL update count by +1 for alloc, -1 for drain, 0 when both occur, and recompute it on flush.
REQ-031 SHALL assert load_block combinationally when any valid entry has ready=0, or has ready=1 and addr[31:2] == load_addr[31:2].
REQ-032 SHALL wrap head and tail from DEPTH-1 to 0.

Reset
REQ-033 SHALL, while reset=0, asynchronously clear all valid bits, head=tail=0, count=0, store_wb=0, wb_addr=0, wb_data=0, wb_sh=0 and wb_tag=0.
REQ-034 SHALL leave alloc_ready=1 and load_block=0 out of reset.
REQ-035 SHALL discard all pending stores when reset is asserted mid-operation, with no partial drain.

Verification
REQ-036 SHALL show that alloc tag 3 (sw), then exec tag 3 with addr 0x10020 and data 0xDEADBEEF, then commit tag 3 -> store_wb=1 for exactly one cycle on the next edge, with wb_addr=0x10020, wb_data=0xDEADBEEF, wb_sh=0, wb_tag=3, and count back to 0.
REQ-037 SHALL show that 8 allocs fill the queue -> alloc_ready=0 and count=8; a 9th alloc is ignored; the head drains -> alloc_ready=1 next cycle; a further alloc lands at index 0 after wrap.
REQ-038 SHALL show that with tags 1..4 allocated and executed and tags 1..2 committed, a flush -> count=2, tags 1 and 2 drain on consecutive cycles, and tags 3 and 4 never appear on store_wb.
REQ-039 SHALL show that one entry with ready=0 -> load_block=1 for any load_addr; after exec with addr 0x100, load_addr 0x102 -> load_block=1 and load_addr 0x104 -> load_block=0.
REQ-040 SHALL show that reset=0 asserted while store_wb=1 -> store_wb=0, count=0 immediately, asynchronous to clk.
REQ-041 SHALL show that alloc and drain in the same cycle at count=8 -> alloc ignored and count=7.

Source files
------------

// File: rtl/store_queue.sv
// Store queue: holds dispatched stores in order and retires committed, resolved ones to data memory.
// Latency: a head entry that is valid, ready and committed appears on store_wb at the next edge; one drain per cycle.
// Backpressure: alloc_ready drops when all DEPTH entries are occupied; allocs offered while full are dropped.
module store_queue #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_valid,
    input  logic [TAG_W-1:0]         alloc_tag,
    input  logic                     alloc_sh,
    output logic                     alloc_ready,
    input  logic                     exec_valid,
    input  logic [TAG_W-1:0]         exec_tag,
    input  logic [31:0]              exec_addr,
    input  logic [31:0]              exec_data,
    input  logic                     commit_valid,
    input  logic [TAG_W-1:0]         commit_tag,
    input  logic                     flush,
    input  logic [31:0]              load_addr,
    output logic                     load_block,
    output logic                     store_wb,
    output logic [31:0]              wb_addr,
    output logic [31:0]              wb_data,
    output logic                     wb_sh,
    output logic [TAG_W-1:0]         wb_tag,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] vld_q, vld_d, rdy_q, rdy_d, cmt_q, cmt_d, sh_q, sh_d;
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [TAG_W-1:0] tag_d  [DEPTH];
    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d, ncmt;

    logic             store_wb_q, wb_sh_q;
    logic [31:0]      wb_addr_q, wb_data_q;
    logic [TAG_W-1:0] wb_tag_q;

    logic drain, do_alloc;

    assign alloc_ready = (count_q != CW'(DEPTH));
    assign do_alloc    = alloc_valid & alloc_ready;
    assign drain       = vld_q[head_q] & rdy_q[head_q] & cmt_q[head_q];

    assign store_wb = store_wb_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign wb_sh    = wb_sh_q;
    assign wb_tag   = wb_tag_q;
    assign count    = count_q;

    // Next-state for entries and pointers; flush overrides alloc/exec/commit, drain always applies last.
    always_comb begin
        vld_d   = vld_q;
        rdy_d   = rdy_q;
        cmt_d   = cmt_q;
        sh_d    = sh_q;
        tag_d   = tag_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ncmt    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ncmt = ncmt + CW'(vld_q[i] & cmt_q[i]);
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!cmt_q[i]) begin
                    vld_d[i] = 1'b0;
                    rdy_d[i] = 1'b0;
                end
            end
            // Committed entries sit contiguously from head, so the surviving run ends here.
            tail_d  = head_q + ncmt[PW-1:0];
            count_d = ncmt - CW'(drain);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (exec_valid && vld_q[i] && tag_q[i] == exec_tag) begin
                    addr_d[i] = exec_addr;
                    data_d[i] = exec_data;
                    rdy_d[i]  = 1'b1;
                end
                if (commit_valid && vld_q[i] && tag_q[i] == commit_tag) begin
                    cmt_d[i] = 1'b1;
                end
            end
            if (do_alloc) begin
                vld_d[tail_q] = 1'b1;
                rdy_d[tail_q] = 1'b0;
                cmt_d[tail_q] = 1'b0;
                sh_d[tail_q]  = alloc_sh;
                tag_d[tail_q] = alloc_tag;
                tail_d        = tail_q + PW'(1);
            end
            count_d = count_q + CW'(do_alloc) - CW'(drain);
        end
        if (drain) begin
            vld_d[head_q] = 1'b0;
            rdy_d[head_q] = 1'b0;
            cmt_d[head_q] = 1'b0;
            head_d        = head_q + PW'(1);
        end
    end

    // A load is held back by any unresolved store or by a resolved store to the same word.
    always_comb begin
        load_block = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (!rdy_q[i] || ((addr_q[i] ^ load_addr) & 32'hFFFF_FFFC) == 32'h0)) begin
                load_block = 1'b1;
            end
        end
    end

    // State registers; reset discards every pending store and any in-flight write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q      <= '0;
            rdy_q      <= '0;
            cmt_q      <= '0;
            sh_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]  <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            store_wb_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
            wb_sh_q    <= 1'b0;
            wb_tag_q   <= '0;
        end else begin
            vld_q      <= vld_d;
            rdy_q      <= rdy_d;
            cmt_q      <= cmt_d;
            sh_q       <= sh_d;
            tag_q      <= tag_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            store_wb_q <= drain;
            if (drain) begin
                wb_addr_q <= addr_q[head_q];
                wb_data_q <= data_q[head_q];
                wb_sh_q   <= sh_q[head_q];
                wb_tag_q  <= tag_q[head_q];
            end
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: table of one-cycle vectors plus hand sequences for
// async reset mid-drain, fill/wrap and alloc-while-full with a simultaneous drain.
// Outputs are sampled 1 time unit after the rising edge; inputs change right after sampling.
module tb_store_queue;

    localparam int DEPTH = 8;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             alloc_valid, alloc_sh, alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             exec_valid;
    logic [TAG_W-1:0] exec_tag;
    logic [31:0]      exec_addr, exec_data;
    logic             commit_valid;
    logic [TAG_W-1:0] commit_tag;
    logic             flush;
    logic [31:0]      load_addr;
    logic             load_block, store_wb, wb_sh;
    logic [31:0]      wb_addr, wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic [3:0]       count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    store_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_sh(alloc_sh), .alloc_ready(alloc_ready),
        .exec_valid(exec_valid), .exec_tag(exec_tag), .exec_addr(exec_addr), .exec_data(exec_data),
        .commit_valid(commit_valid), .commit_tag(commit_tag), .flush(flush),
        .load_addr(load_addr), .load_block(load_block),
        .store_wb(store_wb), .wb_addr(wb_addr), .wb_data(wb_data), .wb_sh(wb_sh), .wb_tag(wb_tag),
        .count(count)
    );

    typedef struct {
        logic        a;
        logic [4:0]  atag;
        logic        ash;
        logic        e;
        logic [4:0]  etag;
        logic [31:0] eaddr;
        logic [31:0] edata;
        logic        c;
        logic [4:0]  ctag;
        logic        f;
        logic [31:0] laddr;
        logic [3:0]  cnt;
        logic        rdy;
        logic        blk;
        logic        wb;
        logic [4:0]  wtag;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic        wsh;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic a, input logic [4:0] atag, input logic ash,
                       input logic e, input logic [4:0] etag, input logic [31:0] eaddr, input logic [31:0] edata,
                       input logic c, input logic [4:0] ctag, input logic f, input logic [31:0] laddr,
                       input logic [3:0] cnt, input logic rdy, input logic blk,
                       input logic wb, input logic [4:0] wtag, input logic [31:0] waddr,
                       input logic [31:0] wdata, input logic wsh);
        vec_t v;
        v.a = a; v.atag = atag; v.ash = ash;
        v.e = e; v.etag = etag; v.eaddr = eaddr; v.edata = edata;
        v.c = c; v.ctag = ctag; v.f = f; v.laddr = laddr;
        v.cnt = cnt; v.rdy = rdy; v.blk = blk;
        v.wb = wb; v.wtag = wtag; v.waddr = waddr; v.wdata = wdata; v.wsh = wsh;
        vecs.push_back(v);
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_tag = '0; alloc_sh = 1'b0;
        exec_valid = 1'b0; exec_tag = '0; exec_addr = '0; exec_data = '0;
        commit_valid = 1'b0; commit_tag = '0; flush = 1'b0; load_addr = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string n, input logic wb, input logic [4:0] tag);
        chk({n, " store_wb"}, 32'(store_wb), 32'(wb));
        chk({n, " wb_tag"}, 32'(wb_tag), 32'(tag));
    endtask

    initial begin
        idle();
        reset = 1'b0;
        #12;
        chk("rst count", 32'(count), 32'd0);
        chk("rst alloc_ready", 32'(alloc_ready), 32'd1);
        chk("rst load_block", 32'(load_block), 32'd0);
        chk("rst store_wb", 32'(store_wb), 32'd0);
        chk("rst wb_addr", wb_addr, 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst wb_tag", 32'(wb_tag), 32'd0);
        chk("rst wb_sh", 32'(wb_sh), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        //   a atag ash  e etag eaddr        edata          c ctag f laddr       cnt rdy blk wb wtag waddr     wdata          wsh
        add(1, 3, 0,  0, 0, 0,           0,             0, 0, 0, 0,          1, 1, 1,  0, 0, 0,        0,             0);
        add(0, 0, 0,  1, 3, 'h10020,     'hDEADBEEF,    0, 0, 0, 'h10020,    1, 1, 1,  0, 0, 0,        0,             0);
        add(0, 0, 0,  0, 0, 0,           0,             1, 3, 0, 0,          1, 1, 0,  0, 0, 0,        0,             0);
        add(0, 0, 0,  0, 0, 0,           0,             0, 0, 0, 0,          0, 1, 0,  1, 3, 'h10020,  'hDEADBEEF,    0);
        add(0, 0, 0,  0, 0, 0,           0,             0, 0, 0, 0,          0, 1, 0,  0, 3, 'h10020,  'hDEADBEEF,    0);
        add(1, 7, 1,  0, 0, 0,           0,             0, 0, 0, 'h5555,     1, 1, 1,  0, 3, 'h10020,  'hDEADBEEF,    0);
        add(0, 0, 0,  1, 7, 'h100,       'h1234,        0, 0, 0, 'h102,      1, 1, 1,  0, 3, 'h10020,  'hDEADBEEF,    0);
        add(0, 0, 0,  0, 0, 0,           0,             0, 0, 0, 'h104,      1, 1, 0,  0, 3, 'h10020,  'hDEADBEEF,    0);
        add(0, 0, 0,  0, 0, 0,           0,             0, 0, 0, 'hFC,       1, 1, 0,  0, 3, 'h10020,  'hDEADBEEF,    0);
        add(0, 0, 0,  0, 0, 0,           0,             1, 7, 0, 'h103,      1, 1, 1,  0, 3, 'h10020,  'hDEADBEEF,    0);
        add(0, 0, 0,  0, 0, 0,           0,             0, 0, 0, 'h100,      0, 1, 0,  1, 7, 'h100,    'h1234,        1);
        add(0, 0, 0,  1, 9, 'h100,       5,             0, 0, 0, 'h100,      0, 1, 0,  0, 7, 'h100,    'h1234,        1);
        add(1, 1, 0,  0, 0, 0,           0,             0, 0, 0, 0,          1, 1, 1,  0, 7, 'h100,    'h1234,        1);
        add(1, 2, 0,  0, 0, 0,           0,             0, 0, 0, 0,          2, 1, 1,  0, 7, 'h100,    'h1234,        1);
        add(1, 3, 0,  0, 0, 0,           0,             0, 0, 0, 0,          3, 1, 1,  0, 7, 'h100,    'h1234,        1);
        add(1, 4, 0,  1, 3, 'h300,       'h33,          0, 0, 0, 0,          4, 1, 1,  0, 7, 'h100,    'h1234,        1);
        add(0, 0, 0,  1, 4, 'h400,       'h44,          1, 1, 0, 0,          4, 1, 1,  0, 7, 'h100,    'h1234,        1);
        add(0, 0, 0,  0, 0, 0,           0,             1, 2, 0, 0,          4, 1, 1,  0, 7, 'h100,    'h1234,        1);
        add(1, 9, 0,  1, 1, 'h200,       'h11,          0, 0, 1, 'h300,      2, 1, 1,  0, 7, 'h100,    'h1234,        1);
        add(0, 0, 0,  1, 3, 'h300,       'h33,          0, 0, 0, 'h300,      2, 1, 1,  0, 7, 'h100,    'h1234,        1);
        add(0, 0, 0,  1, 1, 'h200,       'h11,          0, 0, 0, 'h300,      2, 1, 1,  0, 7, 'h100,    'h1234,        1);
        add(0, 0, 0,  1, 2, 'h204,       'h22,          0, 0, 0, 'h300,      1, 1, 0,  1, 1, 'h200,    'h11,          0);
        add(0, 0, 0,  0, 0, 0,           0,             0, 0, 0, 'h204,      0, 1, 0,  1, 2, 'h204,    'h22,          0);
        add(0, 0, 0,  0, 0, 0,           0,             0, 0, 0, 0,          0, 1, 0,  0, 2, 'h204,    'h22,          0);

        foreach (vecs[i]) begin
            alloc_valid = vecs[i].a; alloc_tag = vecs[i].atag; alloc_sh = vecs[i].ash;
            exec_valid = vecs[i].e; exec_tag = vecs[i].etag; exec_addr = vecs[i].eaddr; exec_data = vecs[i].edata;
            commit_valid = vecs[i].c; commit_tag = vecs[i].ctag; flush = vecs[i].f; load_addr = vecs[i].laddr;
            cycle();
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].cnt));
            chk($sformatf("v%0d alloc_ready", i), 32'(alloc_ready), 32'(vecs[i].rdy));
            chk($sformatf("v%0d load_block", i), 32'(load_block), 32'(vecs[i].blk));
            chk($sformatf("v%0d store_wb", i), 32'(store_wb), 32'(vecs[i].wb));
            chk($sformatf("v%0d wb_tag", i), 32'(wb_tag), 32'(vecs[i].wtag));
            chk($sformatf("v%0d wb_addr", i), wb_addr, vecs[i].waddr);
            chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].wdata);
            chk($sformatf("v%0d wb_sh", i), 32'(wb_sh), 32'(vecs[i].wsh));
        end

        // Async reset while a drain is on store_wb and another store is pending.
        idle(); alloc_valid = 1'b1; alloc_tag = 5'd30;
        cycle();
        idle(); alloc_valid = 1'b1; alloc_tag = 5'd31;
        exec_valid = 1'b1; exec_tag = 5'd30; exec_addr = 32'h80; exec_data = 32'hAA;
        commit_valid = 1'b1; commit_tag = 5'd30;
        cycle();
        idle();
        cycle();
        chk_wb("pre-rst", 1'b1, 5'd30);
        chk("pre-rst count", 32'(count), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mid-rst store_wb", 32'(store_wb), 32'd0);
        chk("mid-rst count", 32'(count), 32'd0);
        chk("mid-rst wb_tag", 32'(wb_tag), 32'd0);
        chk("mid-rst wb_addr", wb_addr, 32'd0);
        chk("mid-rst alloc_ready", 32'(alloc_ready), 32'd1);
        chk("mid-rst load_block", 32'(load_block), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Fill from index 0, overflow attempts, drain while full, wrap to index 0.
        for (int i = 0; i < 8; i++) begin
            idle(); alloc_valid = 1'b1; alloc_tag = 5'(10 + i);
            cycle();
            chk($sformatf("fill%0d count", i), 32'(count), 32'(i + 1));
            chk($sformatf("fill%0d alloc_ready", i), 32'(alloc_ready), (i < 7) ? 32'd1 : 32'd0);
        end
        idle(); alloc_valid = 1'b1; alloc_tag = 5'd18;
        cycle();
        chk("ninth count", 32'(count), 32'd8);
        chk("ninth alloc_ready", 32'(alloc_ready), 32'd0);
        idle(); alloc_valid = 1'b1; alloc_tag = 5'd19;
        exec_valid = 1'b1; exec_tag = 5'd10; exec_addr = 32'h2000 + 32'd40; exec_data = 32'd10;
        commit_valid = 1'b1; commit_tag = 5'd10;
        cycle();
        chk("full-rc count", 32'(count), 32'd8);
        chk("full-rc store_wb", 32'(store_wb), 32'd0);
        idle(); alloc_valid = 1'b1; alloc_tag = 5'd20;
        cycle();
        chk_wb("full-drain", 1'b1, 5'd10);
        chk("full-drain count", 32'(count), 32'd7);
        chk("full-drain alloc_ready", 32'(alloc_ready), 32'd1);
        idle(); alloc_valid = 1'b1; alloc_tag = 5'd21;
        cycle();
        chk("wrap count", 32'(count), 32'd8);
        chk("wrap alloc_ready", 32'(alloc_ready), 32'd0);

        begin
            logic [4:0] order [8];
            for (int k = 0; k < 7; k++) order[k] = 5'(11 + k);
            order[7] = 5'd21;
            for (int k = 0; k < 8; k++) begin
                idle(); exec_valid = 1'b1; exec_tag = order[k];
                exec_addr = 32'h2000 + 32'(order[k]) * 4; exec_data = 32'(order[k]);
                commit_valid = 1'b1; commit_tag = order[k];
                cycle();
                if (k > 0) begin
                    chk_wb($sformatf("drain%0d", k - 1), 1'b1, order[k - 1]);
                    chk($sformatf("drain%0d wb_addr", k - 1), wb_addr, 32'h2000 + 32'(order[k - 1]) * 4);
                    chk($sformatf("drain%0d count", k - 1), 32'(count), 32'(8 - k));
                end
            end
            idle();
            cycle();
            chk_wb("drain7", 1'b1, order[7]);
            chk("drain7 wb_data", wb_data, 32'd21);
            chk("drain7 count", 32'(count), 32'd0);
            cycle();
            chk_wb("empty", 1'b0, order[7]);
            chk("empty count", 32'(count), 32'd0);
            chk("empty alloc_ready", 32'(alloc_ready), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
